// File: rtl/prog_seq_detector_if.sv
// prog_seq_detector_if: serial bit, configuration and status bundle of the sequence detector.
interface prog_seq_detector_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   localparam int LEN_W = $clog2(WIDTH + 1);
   logic             data_in;
   logic             in_valid;
   logic             cfg_load;
   logic [WIDTH-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic             cnt_clr;
   logic             seq_detected;
   logic [WIDTH-1:0] current_seq;
   logic [CNT_W-1:0] match_count;
   logic             count_sat;
   modport master (
      output data_in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      input  seq_detected, current_seq, match_count, count_sat
   );
   modport slave (
      input  data_in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      output seq_detected, current_seq, match_count, count_sat
   );
endinterface

// File: rtl/prog_seq_detector.sv
// prog_seq_detector: runtime-programmable Moore serial sequence detector with saturating match counter.
module prog_seq_detector #(
   parameter int               WIDTH       = 4,
   parameter int               CNT_W       = 8,
   parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(4'b1101),
   parameter logic             DEF_OVERLAP = 1'b1
) (
   input logic                 clk,
   input logic                 reset_n,
   prog_seq_detector_if.slave  bus
);
   localparam int LEN_W = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {FILL, SCAN, DETECT} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] pattern, seq_q, seq_n, mask;
   logic [WIDTH:0]   shifted;
   logic [LEN_W-1:0] len, fill, fill_n, fill_d;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             overlap, accept, len_ok, match, sat;
   // fill counts bits since the last clear; a match needs at least len of them
   always_comb begin
      accept  = bus.in_valid & ~bus.cfg_load;
      shifted = {seq_q, bus.data_in};
      seq_n   = shifted[WIDTH-1:0];
      fill_n  = (fill == LEN_W'(WIDTH)) ? fill : fill + 1'b1;
      len_ok  = (len != '0) && (len <= LEN_W'(WIDTH));
      for (int i = 0; i < WIDTH; i++) mask[i] = LEN_W'(i) < len;
      match   = len_ok && (fill_n >= len) && (((seq_n ^ pattern) & mask) == '0);
      state_n = !accept ? state : (fill_n < len) ? FILL : match ? DETECT : SCAN;
      fill_d  = (match && !overlap) ? '0 : fill_n;
      cnt_n   = bus.cnt_clr ? '0 : (accept && match && !(&cnt)) ? cnt + 1'b1 : cnt;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= FILL;
      else state <= bus.cfg_load ? FILL : state_n;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seq_q   <= '0;
         fill    <= '0;
         pattern <= DEF_PATTERN;
         len     <= LEN_W'(WIDTH);
         overlap <= DEF_OVERLAP;
         cnt     <= '0;
         sat     <= 1'b0;
      end else begin
         cnt <= cnt_n;
         sat <= bus.cnt_clr ? 1'b0 : sat | (&cnt_n);
         if (bus.cfg_load) begin
            pattern <= bus.cfg_pattern;
            len     <= bus.cfg_len;
            overlap <= bus.cfg_overlap;
            seq_q   <= '0;
            fill    <= '0;
         end else if (accept) begin
            seq_q <= seq_n;
            fill  <= fill_d;
         end
      end
   end
   assign bus.seq_detected = (state == DETECT);
   assign bus.current_seq  = seq_q;
   assign bus.match_count  = cnt;
   assign bus.count_sat    = sat;
endmodule

// File: tb/tb_prog_seq_detector.sv
// tb_prog_seq_detector: directed and randomized checks of two detector instances (CNT_W 8 and 2)
// against a history-queue reference model.
module tb_prog_seq_detector;
   localparam int W = 4;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       d, v, ld, ov, clr;
   logic [3:0] pat;
   logic [2:0] len;
   int         checks = 0;
   int         errors = 0;
   always #5 clk = ~clk;
   prog_seq_detector_if #(.WIDTH(W), .CNT_W(8)) bus8 ();
   prog_seq_detector_if #(.WIDTH(W), .CNT_W(2)) bus2 ();
   assign bus8.data_in = d;    assign bus2.data_in = d;
   assign bus8.in_valid = v;   assign bus2.in_valid = v;
   assign bus8.cfg_load = ld;  assign bus2.cfg_load = ld;
   assign bus8.cfg_pattern = pat; assign bus2.cfg_pattern = pat;
   assign bus8.cfg_len = len;  assign bus2.cfg_len = len;
   assign bus8.cfg_overlap = ov; assign bus2.cfg_overlap = ov;
   assign bus8.cnt_clr = clr;  assign bus2.cnt_clr = clr;
   prog_seq_detector #(.WIDTH(W), .CNT_W(8)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus8.slave));
   prog_seq_detector #(.WIDTH(W), .CNT_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   // reference model: accepted-bit history, bits since last clear, detect flag, counts
   bit         hist[$];
   int         fresh, mlen, c8, c2;
   bit  [3:0]  mpat;
   bit         mov, det, hit;
   logic [3:0] expseq;
   always @(posedge clk) begin
      if (!reset_n) begin
         hist.delete(); fresh = 0; det = 0; mpat = 4'b1101; mlen = W; mov = 1; c8 = 0; c2 = 0;
      end else begin
         if (ld) begin
            mpat = pat; mlen = len; mov = ov; hist.delete(); fresh = 0; det = 0;
         end else if (v) begin
            hist.push_back(d);
            if (hist.size() > 8) hist.delete(0);
            fresh++;
            hit = (mlen >= 1) && (mlen <= W) && (fresh >= mlen);
            if (hit) for (int i = 0; i < mlen; i++) if (hist[hist.size()-1-i] != mpat[i]) hit = 0;
            det = hit;
            if (hit) begin
               if (c8 < 255) c8++;
               if (c2 < 3) c2++;
               if (!mov) fresh = 0;
            end
         end
         if (clr) begin c8 = 0; c2 = 0; end
      end
      #1;
      expseq = '0;
      for (int i = 0; i < W; i++) if (i < hist.size()) expseq[i] = hist[hist.size()-1-i];
      chk("seq_detected", bus8.seq_detected, det);
      chk("seq_detected_c2", bus2.seq_detected, det);
      chk("current_seq", bus8.current_seq, expseq);
      chk("match_count", bus8.match_count, c8);
      chk("count_sat", bus8.count_sat, c8 == 255);
      chk("match_count_c2", bus2.match_count, c2);
      chk("count_sat_c2", bus2.count_sat, c2 == 3);
   end
   task automatic send(input logic b);
      d = b; v = 1; @(negedge clk); v = 0;
   endtask
   task automatic load(input logic [3:0] p, input logic [2:0] l, input logic o);
      pat = p; len = l; ov = o; ld = 1; @(negedge clk); ld = 0;
   endtask
   task automatic clear();
      clr = 1; @(negedge clk); clr = 0;
   endtask
   // bits[i] is stream bit i+1; expdet[i] is seq_detected after it
   task automatic run(input string tag, input logic [15:0] bits, input int n, input logic [15:0] expdet);
      for (int i = 0; i < n; i++) begin
         send(bits[i]);
         chk(tag, bus8.seq_detected, expdet[i]);
      end
   endtask
   initial begin
      d = 0; v = 0; ld = 0; pat = 0; len = 0; ov = 0; clr = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      chk("reset_detect", bus8.seq_detected, 0);
      chk("reset_seq", bus8.current_seq, 0);
      chk("reset_count", bus8.match_count, 0);
      chk("reset_sat", bus8.count_sat, 0);
      run("t1_overlap", 16'b1011_0110, 8, 16'b1001_0000);
      chk("t1_count", bus8.match_count, 2);
      load(4'b1101, 3'd4, 1'b0);
      run("t2_nonoverlap", 16'b1011_0110, 8, 16'b0001_0000);
      chk("t2_count", bus8.match_count, 3);
      load(4'b0101, 3'd3, 1'b1);
      run("t3_len3_ov", 16'b10101, 5, 16'b10100);
      load(4'b0101, 3'd3, 1'b0);
      run("t3_len3_nov", 16'b10101, 5, 16'b00100);
      load(4'b1101, 3'd4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(i != 2);
         for (int g = 0; g < 3; g++) begin
            chk("t4_gap_detect", bus8.seq_detected, i == 3);
            if (g < 2) @(negedge clk);
         end
      end
      chk("t4_gap_seq", bus8.current_seq, 4'b1101);
      clear();
      load(4'b1101, 3'd4, 1'b0);
      for (int j = 0; j < 5; j++) run("t5_block", 16'b1011, 4, 16'b1000);
      chk("t5_count2", bus2.match_count, 3);
      chk("t5_sat2", bus2.count_sat, 1);
      chk("t5_count8", bus8.match_count, 5);
      chk("t5_sat8", bus8.count_sat, 0);
      clear();
      chk("t5_clr_count2", bus2.match_count, 0);
      chk("t5_clr_sat2", bus2.count_sat, 0);
      load(4'b0101, 3'd3, 1'b1);
      send(1); send(1); send(0);
      reset_n = 0;
      #2;
      chk("t6_async_seq", bus8.current_seq, 0);
      chk("t6_async_detect", bus8.seq_detected, 0);
      @(negedge clk);
      reset_n = 1;
      send(1);
      chk("t6_after_reset", bus8.seq_detected, 0);
      run("t6_default", 16'b1011, 4, 16'b1000);
      repeat (4000) begin
         ld = $urandom_range(0, 99) < 3;
         clr = $urandom_range(0, 99) < 2;
         v = $urandom_range(0, 99) < 75;
         d = 1'($urandom);
         pat = 4'($urandom);
         len = 3'($urandom_range(0, 7));
         ov = 1'($urandom);
         reset_n = !($urandom_range(0, 999) < 3);
         @(negedge clk);
      end
      ld = 0; clr = 0; v = 0; reset_n = 1;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
